// File: rtl/mvm_stream_loader.sv
// Byte-stream feeder for the KxK MVM core: FIFO plus burst/run sequencer.
// Optional command checking (err output) under MVM_LOADER_CHECK_EN.
module mvm_stream_loader #(
  parameter int K = 16,
  parameter int B = 8,
  parameter int DRAIN = K + 2,
  localparam int KK = K * K,
  localparam int FW = $clog2(KK + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [B-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         mvm_load_matrix,
  output logic         mvm_load_vector,
  output logic         mvm_start,
  output logic [B-1:0] mvm_data,
  input  logic         mvm_done,
  output logic         busy,
  output logic [FW-1:0] fill_count
`ifdef MVM_LOADER_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int PW = (KK > 1) ? $clog2(KK) : 1;
  localparam int MX = (KK > DRAIN) ? KK : DRAIN;
  localparam int CW = $clog2(MX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_BURST  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;

  logic [B-1:0]  mem_q [KK];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mat_q, mat_d;
  logic          first_q, first_d;
  logic [B-1:0]  data_q, data_d;
  logic          push, pop, cmd_accept;
  logic [FW-1:0] len_f;
  logic [CW-1:0] len_c;
`ifdef MVM_LOADER_CHECK_EN
  logic          err_q, err_d;
  logic          mload_q, mload_d;
  logic          vload_q, vload_d;
`endif

  // Handshake readies are forced low while reset is held.
  assign in_ready   = reset_n & (fill_q < FW'(KK));
  assign cmd_ready  = reset_n & (state_q == S_IDLE);
  assign push       = in_valid & in_ready;
  assign cmd_accept = cmd_valid & cmd_ready;
  assign len_f      = mat_q ? FW'(KK) : FW'(K);
  assign len_c      = mat_q ? CW'(KK) : CW'(K);

  assign mvm_load_matrix = (state_q == S_LAUNCH) & mat_q;
  assign mvm_load_vector = (state_q == S_LAUNCH) & ~mat_q;
  assign mvm_start       = (state_q == S_RUN) & first_q;
  assign mvm_data        = data_q;
  assign busy            = (state_q != S_IDLE);
  assign fill_count      = fill_q;
`ifdef MVM_LOADER_CHECK_EN
  assign err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    first_d = 1'b0;
    data_d  = '0;
    pop     = 1'b0;
`ifdef MVM_LOADER_CHECK_EN
    err_d   = err_q;
    mload_d = mload_q;
    vload_d = vload_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          unique case (cmd_op)
            2'b00: begin
              mat_d   = 1'b1;
              state_d = S_WAIT;
            end
            2'b01: begin
              mat_d   = 1'b0;
              state_d = S_WAIT;
            end
            2'b10: begin
`ifdef MVM_LOADER_CHECK_EN
              if (mload_q & vload_q) begin
                state_d = S_RUN;
                first_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
`else
              state_d = S_RUN;
              first_d = 1'b1;
`endif
            end
            default: begin
`ifdef MVM_LOADER_CHECK_EN
              err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      S_WAIT: begin
        if (fill_q >= len_f) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        // Pop one cycle ahead so the registered data lines up with BURST.
        pop     = 1'b1;
        data_d  = mem_q[rd_q];
        cnt_d   = '0;
        state_d = S_BURST;
      end
      S_BURST: begin
        if (cnt_q == len_c - CW'(1)) begin
          state_d = S_GAP;
`ifdef MVM_LOADER_CHECK_EN
          if (mat_q) mload_d = 1'b1;
          else vload_d = 1'b1;
`endif
        end else begin
          pop    = 1'b1;
          data_d = mem_q[rd_q];
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_GAP: state_d = S_IDLE;
      S_RUN: begin
        if (mvm_done) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN - 1)) state_d = S_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = (wr_q == PW'(KK - 1)) ? '0 : wr_q + PW'(1);
    if (pop)  rd_d = (rd_q == PW'(KK - 1)) ? '0 : rd_q + PW'(1);
    fill_d = fill_q + FW'(push) - FW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mat_q   <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
`ifdef MVM_LOADER_CHECK_EN
      err_q   <= 1'b0;
      mload_q <= 1'b0;
      vload_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      first_q <= first_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
`ifdef MVM_LOADER_CHECK_EN
      err_q   <= err_d;
      mload_q <= mload_d;
      vload_q <= vload_d;
`endif
    end
  end

endmodule

// File: doc/mvm_stream_loader.md
Name: mvm_stream_loader

Overview:
- Upstream feeder for the k×k matrix-vector multiply core.
- Accepts a valid/ready byte stream and a small command interface.
- Buffers operand words in an internal FIFO and replays them to the core as gap-free bursts framed by one-cycle load_matrix/load_vector/start pulses.
- After a run it holds off new commands until the core has drained its result vector.

Parameters:
K, 16, matrix dimension; matrix burst = K*K words, vector burst = K words
B, 8, operand word width
DRAIN, K+2, cycles after mvm_done before the next command is accepted

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 load matrix, 01 load vector, 10 run, 11 reserved
in_data  in  B  operand word
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a word
mvm_load_matrix  out  1  one-cycle pulse to core
mvm_load_vector  out  1  one-cycle pulse to core
mvm_start  out  1  one-cycle pulse to core
mvm_data  out  B  word to core data input
mvm_done  in  1  core completion pulse
busy  out  1  high in every state except IDLE
fill_count  out  clog2(K*K+1)  words held in FIFO

Behaviour:
- Reset: asynchronous, active-low; no other reset exists.
  - While reset_n=0: all outputs 0, including cmd_ready and in_ready.
  - FIFO empty, state IDLE.
- Reset asserted mid-burst or mid-run aborts immediately with no flush; the core must be reset alongside.
- FIFO:
  - Depth K*K, width B.
  - in_ready = (fill_count < K*K), combinational from the count.
  - Push on in_valid & in_ready in any state.
  - Simultaneous push and pop leaves fill_count unchanged.
  - Pointers wrap modulo K*K.
- States: IDLE, WAIT_FILL, LAUNCH, BURST, GAP, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept: op 00 sets len=K*K and goes to WAIT_FILL; op 01 sets len=K and goes to WAIT_FILL; op 10 goes to RUN with mvm_start=1 in the first RUN cycle only.
  - op 11 is consumed with no effect; stay in IDLE.
- WAIT_FILL: remain until fill_count >= len (stall indefinitely), then go to LAUNCH.
- LAUNCH: exactly one cycle; mvm_load_matrix or mvm_load_vector = 1 per the latched op.
- BURST:
  - With the pulse at cycle t, word i (0-based, FIFO order) is on mvm_data at cycle t+1+i for i = 0..len-1.
  - No gaps; one pop per cycle.
  - mvm_data is registered and is 0 outside BURST.
- GAP: one idle cycle, then IDLE. cmd_ready returns at cycle t+len+2.
- RUN:
  - Wait for mvm_done; no timeout.
  - On mvm_done go to DRAIN and count DRAIN cycles, then IDLE.
  - mvm_done outside RUN is ignored.
- Extra FIFO words beyond len remain for the next command.
- Commands never overlap: cmd_ready=0 in all non-IDLE states.

Optional Feature:
- Macro: MVM_LOADER_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0, sticky until reset).
  - Tracks matrix_loaded and vector_loaded flags, each set at the end of the matching BURST.
  - An op 10 accepted while either flag is 0 is consumed and sets err=1; no mvm_start is issued and the state stays IDLE.
  - op 11 also sets err.
- When not defined: no err port and no checking; op 10 always runs.

Test Plan:
- Reset; push words 0..255 continuously; cmd 00 → one mvm_load_matrix pulse at t; mvm_data=0..255 on t+1..t+256; cmd_ready=1 at t+258; fill_count=0.
- Cmd 01 with FIFO empty; feed 16 words (values 0x10..0x1F) with random in_valid gaps → no pulse until fill_count=16; then burst 0x10..0x1F with no gaps.
- Push 257 words with no command → in_ready=0 at fill_count=256 and word 257 held; cmd 00 → in_ready=1 during burst; fill_count=1 after GAP.
- Cmd 10 → mvm_start high exactly one cycle; mvm_done 50 cycles later → busy stays 1 for 18 more cycles; cmd_ready=1 on the next cycle; a stray mvm_done in IDLE changes nothing.
- MVM_LOADER_CHECK_EN defined: after reset, cmd 10 → no mvm_start, err=1 and it stays 1. Undefined: the same stimulus produces an mvm_start pulse.
- reset_n driven low asynchronously at BURST word 100 → all outputs 0 without waiting for a clock edge; after release, fill_count=0 and state is IDLE.
